// File: rtl/t48_pack.sv
`default_nettype none
// ============================================================================
//  Module      : t48_pack
//  Description : Shared constants for the T48 quasi-bidirectional ports:
//                write-mode encoding, default geometry and reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package t48_pack;

  // Latch write modes; the unused encoding behaves like MOV.
  typedef enum logic [1:0] {
    WM_MOV = 2'b00,
    WM_ANL = 2'b01,
    WM_ORL = 2'b10,
    WM_RSV = 2'b11
  } wmode_t;

  localparam int          DEF_WIDTH        = 8;
  localparam int          DEF_LOW_W        = 4;
  localparam int          DEF_LOWIMP_TICKS = 2;
  // Wide enough for the largest supported port; sliced to WIDTH at use.
  localparam logic [15:0] DEF_RESET_VAL    = 16'hFFFF;

endpackage : t48_pack
`default_nettype wire

// File: rtl/t48_lowimp_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : t48_lowimp_cnt
//  Description : Per-group strong-drive pulse generator. A write marks the
//                group pending; the next output tick loads the pulse length
//                and the pulse then counts down on the following ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module t48_lowimp_cnt #(
  parameter int LOWIMP_TICKS = 2
) (
  input  logic clk_i,
  input  logic res_i,
  input  logic tick_i,
  input  logic set_i,
  input  logic trig_i,
  output logic low_imp_o
);

  localparam logic [3:0] LOAD_VAL = LOWIMP_TICKS[3:0];

  logic       pend;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  // Next count: a pending write or trigger reloads, otherwise count down.
  always_comb begin
    cnt_next = cnt;
    if (tick_i) begin
      if (pend || trig_i) begin
        cnt_next = LOAD_VAL;
      end else if (cnt != 4'd0) begin
        cnt_next = cnt - 4'd1;
      end
    end
  end

  // Pending flag (set beats tick-clear), counter and registered drive flag.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      pend      <= 1'b0;
      cnt       <= 4'd0;
      low_imp_o <= 1'b0;
    end else begin
      if (set_i) begin
        pend <= 1'b1;
      end else if (tick_i) begin
        pend <= 1'b0;
      end
      cnt <= cnt_next;
      if (tick_i) begin
        low_imp_o <= (cnt_next != 4'd0);
      end
    end
  end

endmodule : t48_lowimp_cnt
`default_nettype wire

// File: rtl/t48_qbport.sv
`default_nettype none
// ============================================================================
//  Module      : t48_qbport
//  Description : Parametrised T48 quasi-bidirectional port. Holds the port
//                latch (MOV/ANL/ORL and expander-nibble writes), overlays
//                PCH on the low group and produces per-group strong-drive
//                pulses timed by the xtal enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module t48_qbport
  import t48_pack::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               LOW_W        = DEF_LOW_W,
  parameter int               LOWIMP_TICKS = DEF_LOWIMP_TICKS,
  parameter logic [WIDTH-1:0] RESET_VAL    = DEF_RESET_VAL[WIDTH-1:0]
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic             en_clk_i,
  input  logic             xtal_en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             write_i,
  input  logic [1:0]       wmode_i,
  input  logic             write_exp_i,
  input  logic             read_i,
  input  logic             read_reg_i,
  input  logic             read_exp_i,
  input  logic             output_pch_i,
  input  logic [LOW_W-1:0] pch_i,
  input  logic [WIDTH-1:0] port_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] port_o,
  output logic             low_imp_l_o,
  output logic             low_imp_h_o
);

  logic [WIDTH-1:0] latch;
  logic [WIDTH-1:0] write_val;
  logic [WIDTH-1:0] drive_val;
  logic             output_pch_q;
  logic             pch_toggle;
  logic             set_l;
  logic             set_h;

  // Full-port write value according to the selected logic operation.
  always_comb begin
    write_val = data_i;
    case (wmode_t'(wmode_i))
      WM_ANL:  write_val = latch & data_i;
      WM_ORL:  write_val = latch | data_i;
      default: write_val = data_i;
    endcase
  end

  // Port latch; a full write takes priority over an expander write.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      latch <= RESET_VAL;
    end else if (en_clk_i) begin
      if (write_i) begin
        latch <= write_val;
      end else if (write_exp_i) begin
        latch[LOW_W-1:0] <= data_i[LOW_W-1:0];
      end
    end
  end

  // Pin drive value: the low group carries PCH while the overlay is on.
  always_comb begin
    drive_val = latch;
    if (output_pch_i) begin
      drive_val[LOW_W-1:0] = pch_i;
    end
  end

  // Output register and overlay history, both advanced on xtal ticks.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      port_o       <= RESET_VAL;
      output_pch_q <= 1'b0;
    end else if (xtal_en_i) begin
      port_o       <= drive_val;
      output_pch_q <= output_pch_i;
    end
  end

  assign pch_toggle = output_pch_q ^ output_pch_i;
  assign set_l      = en_clk_i & (write_i | write_exp_i);
  assign set_h      = en_clk_i & write_i;

  t48_lowimp_cnt #(
    .LOWIMP_TICKS (LOWIMP_TICKS)
  ) u_cnt_l (
    .clk_i     (clk_i),
    .res_i     (res_i),
    .tick_i    (xtal_en_i),
    .set_i     (set_l),
    .trig_i    (pch_toggle),
    .low_imp_o (low_imp_l_o)
  );

  t48_lowimp_cnt #(
    .LOWIMP_TICKS (LOWIMP_TICKS)
  ) u_cnt_h (
    .clk_i     (clk_i),
    .res_i     (res_i),
    .tick_i    (xtal_en_i),
    .set_i     (set_h),
    .trig_i    (1'b0),
    .low_imp_o (low_imp_h_o)
  );

  // Combinational read mux: latch, low group of the pins, or full pins.
  always_comb begin
    data_o = '1;
    if (read_i) begin
      if (read_reg_i) begin
        data_o = latch;
      end else if (read_exp_i) begin
        data_o             = '0;
        data_o[LOW_W-1:0]  = port_i[LOW_W-1:0];
      end else begin
        data_o = port_i;
      end
    end
  end

endmodule : t48_qbport
`default_nettype wire

// File: tb/tb_t48_qbport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t48_qbport
//  Description : Directed, scoreboard-checked bench for t48_qbport (8-bit
//                default instance plus a 12-bit instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t48_qbport;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        en_clk = 1'b0;
  logic        xtal_en = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        write = 1'b0;
  logic [1:0]  wmode = 2'b00;
  logic        write_exp = 1'b0;
  logic        read = 1'b0;
  logic        read_reg = 1'b0;
  logic        read_exp = 1'b0;
  logic        output_pch = 1'b0;
  logic [3:0]  pch = 4'h0;
  logic [7:0]  port_in = 8'h00;
  logic [11:0] port12_in = 12'h000;

  logic [7:0]  data_out, port_out;
  logic        lil, lih;
  logic [11:0] data12_out, port12_out;
  logic        lil12, lih12;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  t48_qbport u8 (
    .clk_i(clk), .res_i(res_n), .en_clk_i(en_clk), .xtal_en_i(xtal_en),
    .data_i(data), .write_i(write), .wmode_i(wmode), .write_exp_i(write_exp),
    .read_i(read), .read_reg_i(read_reg), .read_exp_i(read_exp),
    .output_pch_i(output_pch), .pch_i(pch), .port_i(port_in),
    .data_o(data_out), .port_o(port_out),
    .low_imp_l_o(lil), .low_imp_h_o(lih)
  );

  t48_qbport #(.WIDTH(12), .LOW_W(4)) u12 (
    .clk_i(clk), .res_i(res_n), .en_clk_i(en_clk), .xtal_en_i(xtal_en),
    .data_i({4'h0, data}), .write_i(write), .wmode_i(wmode),
    .write_exp_i(write_exp), .read_i(read), .read_reg_i(read_reg),
    .read_exp_i(read_exp), .output_pch_i(output_pch), .pch_i(pch),
    .port_i(port12_in), .data_o(data12_out), .port_o(port12_out),
    .low_imp_l_o(lil12), .low_imp_h_o(lih12)
  );

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %h with no expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock: drive enables, wait the edge, sample 1 ns later, clear strobes.
  task automatic step(input logic en, input logic xt);
    en_clk  = en;
    xtal_en = xt;
    @(posedge clk);
    #1;
    en_clk    = 1'b0;
    xtal_en   = 1'b0;
    write     = 1'b0;
    write_exp = 1'b0;
  endtask

  task automatic tick_check(input string tag, input logic [7:0] p,
                            input logic l, input logic h);
    push({tag, "_port"}, {8'h00, p});
    push({tag, "_l"}, {15'h0, l});
    push({tag, "_h"}, {15'h0, h});
    step(1'b0, 1'b1);
    pop_check({8'h00, port_out});
    pop_check({15'h0, lil});
    pop_check({15'h0, lih});
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    push("rst_port", 16'h00FF); push("rst_l", 16'h0); push("rst_h", 16'h0);
    push("rst_port12", 16'h0FFF);
    pop_check({8'h00, port_out}); pop_check({15'h0, lil});
    pop_check({15'h0, lih}); pop_check({4'h0, port12_out});
    @(negedge clk);
    res_n = 1'b1;
    read = 1'b1; read_reg = 1'b1;
    push("rst_read_reg", 16'h00FF);
    #1 pop_check({8'h00, data_out});

    // Pin reads
    read_reg = 1'b0; port_in = 8'h3C;
    push("read_pins", 16'h003C);
    #1 pop_check({8'h00, data_out});
    read_exp = 1'b1;
    push("read_exp8", 16'h000C);
    #1 pop_check({8'h00, data_out});
    read_exp = 1'b0; read = 1'b0;
    push("read_idle", 16'h00FF);
    #1 pop_check({8'h00, data_out});

    // MOV 0x5A: port follows on the first tick, pulse lasts two ticks
    data = 8'h5A; wmode = 2'b00; write = 1'b1;
    push("mov_no_tick_port", 16'h00FF);
    step(1'b1, 1'b0);
    pop_check({8'h00, port_out});
    tick_check("mov_t1", 8'h5A, 1'b1, 1'b1);
    tick_check("mov_t2", 8'h5A, 1'b1, 1'b1);
    tick_check("mov_t3", 8'h5A, 1'b0, 1'b0);

    // ANL then ORL
    read = 1'b1; read_reg = 1'b1;
    data = 8'h0F; wmode = 2'b01; write = 1'b1;
    push("anl", 16'h000A);
    step(1'b1, 1'b0);
    pop_check({8'h00, data_out});
    data = 8'h80; wmode = 2'b10; write = 1'b1;
    push("orl", 16'h008A);
    step(1'b1, 1'b0);
    pop_check({8'h00, data_out});
    drain();
    push("orl_port", 16'h008A);
    pop_check({8'h00, port_out});

    // Expander write: low group only, low pulse only
    data = 8'h37; write_exp = 1'b1;
    push("exp_latch", 16'h0087);
    step(1'b1, 1'b0);
    pop_check({8'h00, data_out});
    tick_check("exp_t1", 8'h87, 1'b1, 1'b0);
    tick_check("exp_t2", 8'h87, 1'b1, 1'b0);
    tick_check("exp_t3", 8'h87, 1'b0, 1'b0);

    // PCH overlay on and off, each toggle pulses the low group
    output_pch = 1'b1; pch = 4'h3;
    tick_check("pch_on_t1", 8'h83, 1'b1, 1'b0);
    tick_check("pch_on_t2", 8'h83, 1'b1, 1'b0);
    tick_check("pch_on_t3", 8'h83, 1'b0, 1'b0);
    output_pch = 1'b0;
    tick_check("pch_off_t1", 8'h87, 1'b1, 1'b0);
    tick_check("pch_off_t2", 8'h87, 1'b1, 1'b0);
    tick_check("pch_off_t3", 8'h87, 1'b0, 1'b0);

    // Write coinciding with a tick: old value on that tick, new on the next
    data = 8'h12; wmode = 2'b00; write = 1'b1;
    push("coll_port", 16'h0087); push("coll_l", 16'h0);
    step(1'b1, 1'b1);
    pop_check({8'h00, port_out}); pop_check({15'h0, lil});
    tick_check("coll_t1", 8'h12, 1'b1, 1'b1);
    // Retrigger mid-pulse extends the pulse by a reload
    data = 8'h34; write = 1'b1;
    step(1'b1, 1'b0);
    tick_check("retrig_t1", 8'h34, 1'b1, 1'b1);
    tick_check("retrig_t2", 8'h34, 1'b1, 1'b1);
    tick_check("retrig_t3", 8'h34, 1'b0, 1'b0);

    // Reset mid-pulse clears everything at once
    data = 8'h00; write = 1'b1;
    step(1'b1, 1'b0);
    tick_check("pre_rst", 8'h00, 1'b1, 1'b1);
    res_n = 1'b0;
    push("arst_port", 16'h00FF); push("arst_l", 16'h0); push("arst_h", 16'h0);
    push("arst_latch", 16'h00FF);
    #1;
    pop_check({8'h00, port_out}); pop_check({15'h0, lil});
    pop_check({15'h0, lih}); pop_check({8'h00, data_out});
    @(negedge clk);
    res_n = 1'b1;
    tick_check("post_rst", 8'hFF, 1'b0, 1'b0);

    // 12-bit instance reads
    read_reg = 1'b0; read_exp = 1'b1; port12_in = 12'hFFA;
    push("read_exp12", 16'h000A);
    #1 pop_check({4'h0, data12_out});
    read_exp = 1'b0;
    push("read_pins12", 16'h0FFA);
    #1 pop_check({4'h0, data12_out});

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_t48_qbport
`default_nettype wire
